// File: rtl/m68k_bus_pkg.sv
// Shared encodings for the 68040-style bus slave front end.
// Imported by the front end and by the lane decoder.
package m68k_bus_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam int LINE_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WBEAT = 2'd2,
    RBEAT = 2'd3
  } state_t;

endpackage

// File: rtl/m68k_lane_decode.sv
// Combinational SIZ/A[1:0] decoder producing byte-lane mask and beat count.
// Mask bit 3 corresponds to D31:24 (big-endian lane order).
module m68k_lane_decode
  import m68k_bus_pkg::*;
(
  input  logic [1:0] siz,
  input  logic [1:0] a_lo,
  output logic [3:0] mask,
  output logic [2:0] len
);

  always_comb begin
    mask = 4'b1111;
    len  = 3'd1;
    case (siz)
      SIZ_LINE: len  = 3'(LINE_BEATS);
      SIZ_WORD: mask = a_lo[1] ? 4'b0011 : 4'b1100;
      SIZ_BYTE: mask = 4'b1000 >> a_lo;
      default:  ;
    endcase
  end

endmodule

// File: rtl/m68k_bus_frontend.sv
// CPU bus slave front end: converts one bus cycle into one translator request,
// then streams write/read beats with TA, gating writes on FIFO credit.
module m68k_bus_frontend
  import m68k_bus_pkg::*;
#(
  parameter int DIN_CREDITS = 8,
  parameter int CRW         = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ts_n,
  input  logic        rw,
  input  logic [1:0]  siz,
  input  logic [31:0] a,
  input  logic [31:0] d_i,
  output logic [31:0] d_o,
  output logic        d_oe,
  output logic        ta_n,
  output logic        busy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [2:0]  req_len,
  output logic [31:0] req_addr,
  output logic [3:0]  req_mask,
  output logic        din_valid,
  output logic [31:0] din,
  input  logic        din_pop,
  input  logic        dout_valid,
  input  logic [31:0] dout,
  output logic        dout_ack
);

  localparam logic [CRW-1:0] CREDIT_MAX = CRW'(DIN_CREDITS);

  state_t          state_reg, state_next;
  logic [31:0]     addr_reg;
  logic [1:0]      siz_reg;
  logic            rw_reg;
  logic [2:0]      beat_reg, beat_next;
  logic [CRW-1:0]  credit_reg, credit_next;
  logic            push;
  logic [2:0]      len;

  m68k_lane_decode u_lane_decode (
    .siz  (siz_reg),
    .a_lo (addr_reg[1:0]),
    .mask (req_mask),
    .len  (len)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      siz_reg    <= '0;
      rw_reg     <= 1'b0;
      beat_reg   <= '0;
      credit_reg <= CREDIT_MAX;
    end else begin
      state_reg  <= state_next;
      beat_reg   <= beat_next;
      credit_reg <= credit_next;
      if (state_reg == IDLE && !ts_n) begin
        addr_reg <= a;
        siz_reg  <= siz;
        rw_reg   <= rw;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    req_valid  = 1'b0;
    din_valid  = 1'b0;
    ta_n       = 1'b1;
    d_oe       = 1'b0;
    dout_ack   = 1'b0;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!ts_n) state_next = ISSUE;
      end
      ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) begin
          beat_next  = len;
          state_next = rw_reg ? RBEAT : WBEAT;
        end
      end
      WBEAT: begin
        // A beat is only acknowledged when the write FIFO is guaranteed room.
        if (credit_reg != '0) begin
          din_valid = 1'b1;
          ta_n      = 1'b0;
          push      = 1'b1;
          beat_next = beat_reg - 3'd1;
          if (beat_reg == 3'd1) state_next = IDLE;
        end
      end
      RBEAT: begin
        if (dout_valid) begin
          d_oe      = 1'b1;
          ta_n      = 1'b0;
          dout_ack  = 1'b1;
          beat_next = beat_reg - 3'd1;
          if (beat_reg == 3'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pop and push together cancel; a pop at full credit is dropped.
  always_comb begin
    credit_next = credit_reg;
    if (push && !din_pop)
      credit_next = credit_reg - 1'b1;
    else if (!push && din_pop && credit_reg != CREDIT_MAX)
      credit_next = credit_reg + 1'b1;
  end

  assign busy     = (state_reg != IDLE);
  assign req_we   = !rw_reg;
  assign req_addr = addr_reg;
  assign req_len  = len;
  assign din      = d_i;
  assign d_o      = dout;

endmodule
